// File: rtl/n2_window_stats.sv
// Window statistics over the n2 sample stream: sum/min/max/count per WINDOW
// samples (or per flushed partial window), reported over valid/ready.
module n2_window_stats #(
    parameter  int DW     = 8,
    parameter  int WINDOW = 16,
    localparam int CW     = $clog2(WINDOW) + 1,
    localparam int SW     = DW + $clog2(WINDOW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic [DW-1:0] out_min,
    output logic [DW-1:0] out_max,
    output logic [CW-1:0] out_count
);

    typedef enum logic {ACCUM, REPORT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, s_cnt;
    logic [SW-1:0] acc_sum, sum_n, s_sum;
    logic [DW-1:0] acc_min, min_n, s_min;
    logic [DW-1:0] acc_max, max_n, s_max;
    logic          in_ready_n, out_valid_n;
    logic [SW-1:0] out_sum_n;
    logic [DW-1:0] out_min_n, out_max_n;
    logic [CW-1:0] out_count_n;
    logic          take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            cnt       <= '0;
            acc_sum   <= '0;
            acc_min   <= '1;
            acc_max   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_min   <= '0;
            out_max   <= '0;
            out_count <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            acc_sum   <= sum_n;
            acc_min   <= min_n;
            acc_max   <= max_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_sum   <= out_sum_n;
            out_min   <= out_min_n;
            out_max   <= out_max_n;
            out_count <= out_count_n;
        end
    end

    // Accumulator view with the same-cycle sample folded in; the trigger and
    // the report both use this so the final sample lands in its own window.
    always_comb begin
        take  = in_valid & in_ready;
        s_cnt = cnt + CW'(take);
        s_sum = acc_sum + (take ? SW'(in_data) : '0);
        s_min = (take && in_data < acc_min) ? in_data : acc_min;
        s_max = (take && in_data > acc_max) ? in_data : acc_max;
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        sum_n       = acc_sum;
        min_n       = acc_min;
        max_n       = acc_max;
        in_ready_n  = in_ready;
        out_valid_n = out_valid;
        out_sum_n   = out_sum;
        out_min_n   = out_min;
        out_max_n   = out_max;
        out_count_n = out_count;
        case (state)
            ACCUM: begin
                if ((take && s_cnt == CW'(WINDOW)) || (flush && s_cnt != '0)) begin
                    out_sum_n   = s_sum;
                    out_min_n   = s_min;
                    out_max_n   = s_max;
                    out_count_n = s_cnt;
                    out_valid_n = 1'b1;
                    in_ready_n  = 1'b0;
                    state_n     = REPORT;
                    cnt_n       = '0;
                    sum_n       = '0;
                    min_n       = '1;
                    max_n       = '0;
                end else begin
                    cnt_n = s_cnt;
                    sum_n = s_sum;
                    min_n = s_min;
                    max_n = s_max;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                    state_n     = ACCUM;
                end
            end
            default: state_n = ACCUM;
        endcase
    end

endmodule

// File: tb/tb_n2_window_stats.sv
// Scoreboard bench for n2_window_stats: directed windows push expected reports,
// a negedge monitor retires them on each out_valid&out_ready handshake.
module tb_n2_window_stats;

    localparam int DW = 8, WINDOW = 16, CW = 5, SW = 12;

    typedef struct packed {
        logic [SW-1:0] sum;
        logic [DW-1:0] mn;
        logic [DW-1:0] mx;
        logic [CW-1:0] cnt;
    } rpt_t;

    logic          clk = 0, rst = 1;
    logic          in_valid = 0, flush = 0, out_ready = 1;
    logic [DW-1:0] in_data = 0;
    logic          in_ready, out_valid;
    logic [SW-1:0] out_sum;
    logic [DW-1:0] out_min, out_max;
    logic [CW-1:0] out_count;

    rpt_t q[$];
    int   n_cmp = 0, n_err = 0;

    n2_window_stats #(.DW(DW), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_min(out_min),
        .out_max(out_max), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            rpt_t e;
            if (q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_report: got sum=%0d count=%0d expected none", out_sum, out_count);
            end else begin
                e = q.pop_front();
                chk("rpt_sum", out_sum, e.sum);
                chk("rpt_min", out_min, e.mn);
                chk("rpt_max", out_max, e.mx);
                chk("rpt_count", out_count, e.cnt);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s, input int mn, input int mx, input int c);
        rpt_t e;
        e.sum = SW'(s); e.mn = DW'(mn); e.mx = DW'(mx); e.cnt = CW'(c);
        q.push_back(e);
    endtask

    task automatic send(input int d, input logic fl);
        in_valid = 1; in_data = DW'(d); flush = fl;
        cyc();
        in_valid = 0; flush = 0;
    endtask

    task automatic idle_no_valid(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            chk(name, out_valid, 0);
            cyc();
        end
    endtask

    initial begin
        logic [SW-1:0] hs;
        cyc(); cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_count", out_count, 0);
        rst = 0;

        // Full window of squares, back to back
        push(1240, 0, 225, 16);
        for (int i = 0; i < 16; i++) begin
            chk("sq_in_ready", in_ready, 1);
            in_valid = 1; in_data = DW'(i * i);
            cyc();
        end
        in_valid = 0;
        chk("sq_latency_valid", out_valid, 1);
        chk("sq_in_ready_low", in_ready, 0);
        cyc();
        chk("sq_in_ready_back", in_ready, 1);
        chk("sq_valid_drop", out_valid, 0);

        // Saturating samples
        push(4080, 255, 255, 16);
        for (int i = 0; i < 16; i++) send(255, 0);
        cyc();

        // Partial flush, then empty flush
        push(60, 10, 30, 3);
        send(10, 0); send(20, 0); send(30, 1);
        cyc();
        flush = 1; cyc(); flush = 0;
        idle_no_valid("empty_flush", 4);

        // Backpressure with 0x77 held on the input
        out_ready = 0;
        push(48, 3, 3, 16);
        for (int i = 0; i < 16; i++) send(3, 0);
        in_valid = 1; in_data = 8'h77;
        hs = out_sum;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum_stable", out_sum, hs);
            chk("bp_count", out_count, 16);
            cyc();
        end
        out_ready = 1; in_valid = 0;
        cyc();
        chk("bp_retired", out_valid, 0);
        chk("bp_in_ready_back", in_ready, 1);
        push(5, 5, 5, 1);
        send(5, 1);
        cyc();

        // Flush coinciding with the 16th sample
        push(136, 1, 16, 16);
        for (int i = 1; i <= 16; i++) send(i, i == 16);
        cyc();
        idle_no_valid("no_extra_report", 4);

        // Reset after 7 samples
        for (int i = 0; i < 7; i++) send(9, 0);
        rst = 1; cyc(); rst = 0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_sum", out_sum, 0);
        chk("midrst_min", out_min, 0);
        chk("midrst_count", out_count, 0);
        chk("midrst_in_ready", in_ready, 1);
        push(16, 1, 1, 16);
        for (int i = 0; i < 16; i++) send(1, 0);
        cyc();

        // Reset while a report is pending
        out_ready = 0;
        for (int i = 0; i < 16; i++) send(4, 0);
        chk("rptrst_pending", out_valid, 1);
        rst = 1; cyc(); rst = 0;
        chk("rptrst_valid", out_valid, 0);
        out_ready = 1;
        idle_no_valid("rptrst_quiet", 3);

        for (int k = 0; k < 20 && q.size() != 0; k++) cyc();
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
